// File: rtl/conversor_bin_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Produces the packed [centena][dezena][unidade] word with a start/busy/done handshake.
module conversor_bin_bcd #(
  parameter int LARGURA = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iniciar,
  input  logic [LARGURA-1:0] valor_bin,
  output logic [11:0]        bits_out,
  output logic               pronto,
  output logic               ocupado,
  output logic               estouro
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  typedef enum logic {OCIOSO, CONVERTE} estado_t;

  estado_t            estado_reg;
  logic [LARGURA-1:0] v_reg;
  logic [LARGURA-1:0] v_sat;
  logic               ovf_next;
  logic               ovf_reg;
  logic [11:0]        scratch_reg;
  logic [11:0]        scratch_adj;
  logic [11:0]        scratch_next;
  logic [CW-1:0]      contador_reg;

  // Only a 10-bit input can exceed 999; narrower inputs never saturate.
  generate
    if (LARGURA >= 10) begin : g_sat
      assign ovf_next = (valor_bin > LARGURA'(999));
      assign v_sat    = ovf_next ? LARGURA'(999) : valor_bin;
    end else begin : g_nosat
      assign ovf_next = 1'b0;
      assign v_sat    = valor_bin;
    end
  endgenerate

  // Add-3 correction per digit, no carry between digits.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digito
      assign scratch_adj[4*gi+3:4*gi] = (scratch_reg[4*gi+3:4*gi] >= 4'd5)
                                        ? scratch_reg[4*gi+3:4*gi] + 4'd3
                                        : scratch_reg[4*gi+3:4*gi];
    end
  endgenerate

  assign scratch_next = {scratch_adj[10:0], v_reg[LARGURA-1]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_reg   <= OCIOSO;
      v_reg        <= '0;
      ovf_reg      <= 1'b0;
      scratch_reg  <= 12'h000;
      contador_reg <= '0;
      bits_out     <= 12'h000;
      pronto       <= 1'b0;
      ocupado      <= 1'b0;
      estouro      <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado_reg)
        OCIOSO: begin
          if (iniciar) begin
            v_reg        <= v_sat;
            ovf_reg      <= ovf_next;
            scratch_reg  <= 12'h000;
            contador_reg <= '0;
            ocupado      <= 1'b1;
            estado_reg   <= CONVERTE;
          end
        end
        CONVERTE: begin
          scratch_reg  <= scratch_next;
          v_reg        <= {v_reg[LARGURA-2:0], 1'b0};
          contador_reg <= contador_reg + CW'(1);
          if (contador_reg == ULTIMO) begin
            bits_out   <= scratch_next;
            estouro    <= ovf_reg;
            pronto     <= 1'b1;
            ocupado    <= 1'b0;
            estado_reg <= OCIOSO;
          end
        end
        default: estado_reg <= OCIOSO;
      endcase
    end
  end

endmodule

// File: doc/conversor_bin_bcd.md
Name: conversor_bin_bcd

Overview:
Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one bit per clock. It produces the 12-bit packed BCD word [centena][dezena][unidade] that downstream discretisation and display logic consume. A start/busy/done handshake controls each conversion. Inputs above 999 saturate to 999 and raise a flag.

Parameters:
LARGURA, 10, width of the binary input; legal range 4..10.

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk)
iniciar  input  1  start request; sampled only in OCIOSO
valor_bin  input  LARGURA  unsigned binary value; captured on the accepted iniciar edge
bits_out  output  12  packed BCD result [11:8] centena, [7:4] dezena, [3:0] unidade; registered
pronto  output  1  one-cycle pulse; bits_out/estouro updated this cycle
ocupado  output  1  high while a conversion is in progress
estouro  output  1  registered with bits_out; 1 if the captured valor_bin exceeded 999

Behaviour:
- Reset (reset=0 at an edge): state=OCIOSO; bits_out=12'h000, pronto=0, ocupado=0, estouro=0; shift counter and scratch cleared. Reset has priority over every other input.
- Reset during CONVERTE aborts the conversion: no pronto pulse, bits_out=000.
- States: OCIOSO, CONVERTE. No other states.
- OCIOSO: if iniciar=1 at edge E0:
  - capture v = min(valor_bin, 999) and ovf = (valor_bin > 999);
  - clear the 12-bit BCD scratch; counter=0; go to CONVERTE; ocupado=1 from E0.
  - If LARGURA<10, ovf is constant 0.
- CONVERTE, one iteration per edge:
  - add 3 to each scratch digit >= 5 (all three digits in parallel, combinational);
  - shift {scratch, v} left by 1 with the MSB of v entering bit 0 of scratch;
  - increment counter.
- Completion: on the edge where counter reaches LARGURA (edge E0+LARGURA):
  - bits_out <= final scratch; estouro <= ovf; pronto <= 1; ocupado <= 0; state=OCIOSO.
- Latency: pronto is high in the cycle after edge E0+LARGURA (10 cycles after capture at the default). pronto is cleared at the next edge.
- Throughput: iniciar held high, or asserted in the pronto cycle, is accepted at edge E0+LARGURA+1. Back-to-back period is LARGURA+1 cycles.
- iniciar while ocupado=1: ignored and not queued. valor_bin changes during CONVERTE have no effect.
- bits_out and estouro hold their last value until the next completion or reset. No digit ever exceeds 9.
- Arithmetic: each scratch digit is 4 bits; add-3 does not carry between digits. The shift carries digit MSBs upward. Bits shifted out of centena are discarded; this cannot occur for v <= 999.

Test Plan:
- Reset: hold reset=0 for 2 cycles with iniciar=1 -> bits_out=000, pronto=0, ocupado=0, estouro=0. Release, valor_bin=0, iniciar pulse -> bits_out=12'h000 with pronto.
- Latency: valor_bin=12, iniciar captured at edge E0 -> ocupado=1 from E0; pronto=1 exactly after edge E0+10, one cycle only; bits_out=12'h012, estouro=0.
- Range: 999 -> 12'h999, estouro=0; 1000 -> 12'h999, estouro=1; 1023 -> 12'h999, estouro=1. Then 5 -> 12'h005 with estouro back to 0.
- Category boundaries back-to-back, iniciar held high: 6, 7, 12, 13, 18, 19 -> 006, 007, 012, 013, 018, 019. Pronto every 11 cycles.
- Handshake: iniciar=1 with valor_bin=400 at E0, then iniciar=1 with valor_bin=77 at E0+3 (busy) -> result 12'h400, one pronto only, 77 never converted.
- Abort: start 256, assert reset=0 at E0+5 -> no pronto, bits_out=000. Restart with 256 -> 12'h256.
